rf_fill_sequencer: RTL

- Sequences one operand stream (actv or wgt) from the global buffer (GBF) into the PE-array register-file ping-pong buffers (buf1/buf2).
- Drives the data_avail / w_addr / data / en / bufN_send_finish handshake that pe_array_w_controller expects.
- Instantiated twice at top level: once for actv, once for wgt.
- Fills a buffer only when the array raises that buffer's need_data. Holds send_finish until the array acknowledges with turn_off.

---
 rtl/rf_fill_sequencer.sv | 91 +++++++++
 1 files changed

// File: rtl/rf_fill_sequencer.sv
// rf_fill_sequencer: streams DEPTH-word tiles from the GBF into ping-pong RF buffers on array demand.
module rf_fill_sequencer #(
  parameter int ADDR_BITWIDTH = 2,
  parameter int DEPTH = 4,
  parameter int DATA_BITWIDTH = 512,
  parameter int GBF_ADDR_BITWIDTH = 10,
  parameter int CNT_BITWIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [GBF_ADDR_BITWIDTH-1:0] base_addr,
  input  logic [CNT_BITWIDTH-1:0] num_tiles,
  input  logic rf1_need_data,
  input  logic rf2_need_data,
  input  logic turn_off,
  input  logic [DATA_BITWIDTH-1:0] gbf_rd_data,
  output logic gbf_rd_en,
  output logic [GBF_ADDR_BITWIDTH-1:0] gbf_rd_addr,
  output logic data_avail,
  output logic [ADDR_BITWIDTH-1:0] w_addr,
  output logic [DATA_BITWIDTH-1:0] data,
  output logic wr_valid,
  output logic buf1_send_finish,
  output logic buf2_send_finish,
  output logic busy,
  output logic done
);
  typedef enum logic [2:0] {IDLE, WAIT_NEED, FILL, DRAIN, FINISH} state_t;
  localparam logic [ADDR_BITWIDTH-1:0] K_LAST = ADDR_BITWIDTH'(DEPTH - 1);
  state_t state, state_n;
  logic [GBF_ADDR_BITWIDTH-1:0] rd_ptr;
  logic [CNT_BITWIDTH-1:0] cnt;
  logic [ADDR_BITWIDTH-1:0] k;
  logic [DATA_BITWIDTH-1:0] data_q;
  logic tgt;
  logic ack;
  always_comb begin
    state_n = state;
    ack = state == FINISH && turn_off;
    case (state)
      IDLE:      state_n = (start && num_tiles != '0) ? WAIT_NEED : IDLE;
      WAIT_NEED: state_n = (tgt ? rf2_need_data : rf1_need_data) ? FILL : WAIT_NEED;
      FILL:      state_n = k == K_LAST ? DRAIN : FILL;
      DRAIN:     state_n = FINISH;
      FINISH:    state_n = ack ? (cnt == CNT_BITWIDTH'(1) ? IDLE : WAIT_NEED) : FINISH;
      default:   state_n = IDLE;
    endcase
    gbf_rd_en = state == FILL;
    gbf_rd_addr = gbf_rd_en ? rd_ptr + GBF_ADDR_BITWIDTH'(k) : '0;
    data_avail = state == FILL || state == DRAIN;
    buf1_send_finish = state == FINISH && !tgt;
    buf2_send_finish = state == FINISH && tgt;
    busy = state != IDLE;
    // GBF data lands in the write cycle itself; data_q keeps it stable between writes
    data = wr_valid ? gbf_rd_data : data_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      rd_ptr <= '0;
      cnt <= '0;
      tgt <= 1'b0;
      k <= '0;
      w_addr <= '0;
      wr_valid <= 1'b0;
      data_q <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      wr_valid <= gbf_rd_en;
      done <= 1'b0;
      if (gbf_rd_en) begin
        w_addr <= k;
        k <= k == K_LAST ? '0 : k + 1'b1;
      end
      if (wr_valid) data_q <= gbf_rd_data;
      if (state == IDLE && start) begin
        rd_ptr <= base_addr;
        cnt <= num_tiles;
        done <= num_tiles == '0;
      end
      if (ack) begin
        rd_ptr <= rd_ptr + GBF_ADDR_BITWIDTH'(DEPTH);
        tgt <= !tgt;
        cnt <= cnt - 1'b1;
        done <= cnt == CNT_BITWIDTH'(1);
      end
    end
  end
endmodule
